// File: rtl/upcounter_pkg.sv
// Shared op-codes and FSM state encoding for the Upcounter sequencer.
package upcounter_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } seq_state_t;

endpackage

// File: rtl/Upcounter.sv
// Loadable up-counter datapath; overflow is a registered one-cycle pulse
// following the edge where count wraps from all-ones to zero.
module Upcounter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  // Load has priority over enable; the wrap is flagged one cycle late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (load) begin
        count <= data_in;
      end else if (enable) begin
        count    <= count + WIDTH'(1);
        overflow <= (count == '1);
      end
    end
  end

endmodule

// File: rtl/upcounter_seq.sv
// Command sequencer for the Upcounter: preloads the counter and lets it run
// for a programmed number of wrap-arounds, reporting done/abort/error pulses.
module upcounter_seq
  import upcounter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [REP_W-1:0] cmd_reps,
  output logic             cnt_enable,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_count,
  input  logic             cnt_overflow,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cmd_err,
  output logic [REP_W-1:0] wraps
);

  seq_state_t       state_q, state_d;
  logic             run_flag_q;
  logic [WIDTH-1:0] preload_q;
  logic [REP_W-1:0] reps_q;
  logic [REP_W-1:0] wraps_q;
  logic             final_wrap;
  logic             abort_req;
  logic             unused_status;

  // The live count is only of interest to whoever monitors the counter.
  assign unused_status = ^cnt_count;

  assign final_wrap = cnt_overflow && (wraps_q == (reps_q - REP_W'(1)));
  assign abort_req  = cmd_valid && (cmd_op == OP_ABORT);
  assign wraps      = wraps_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Command latching in IDLE and saturating wrap tally while running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_flag_q <= 1'b0;
      preload_q  <= '0;
      reps_q     <= '0;
      wraps_q    <= '0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        if (cmd_op == OP_LOAD) begin
          preload_q  <= cmd_data;
          run_flag_q <= 1'b0;
        end else if (cmd_op == OP_RUN) begin
          preload_q  <= cmd_data;
          run_flag_q <= 1'b1;
          reps_q     <= cmd_reps;
          wraps_q    <= '0;
        end
      end
      if (state_q == RUN && cnt_overflow && wraps_q != '1) begin
        wraps_q <= wraps_q + REP_W'(1);
      end
    end
  end

  // Completion beats a simultaneous ABORT, which is then silently consumed.
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    cnt_enable = 1'b0;
    cnt_load   = 1'b0;
    cnt_data   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    cmd_err    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_op == OP_LOAD || cmd_op == OP_RUN)) state_d = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        cnt_load = 1'b1;
        cnt_data = preload_q;
        if (!run_flag_q)       state_d = IDLE;
        else if (reps_q == '0) state_d = DONE;
        else                   state_d = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        cmd_ready  = 1'b1;
        cnt_enable = !final_wrap && !abort_req;
        if (final_wrap) begin
          state_d = DONE;
        end else if (abort_req) begin
          state_d = IDLE;
          aborted = 1'b1;
        end else if (cmd_valid && (cmd_op == OP_LOAD || cmd_op == OP_RUN)) begin
          cmd_err = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
